fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage, plus the IF/ID pipeline register.
- Holds the PC and issues single-outstanding requests to instruction memory over a REQ/READY handshake.
- Presents INSTRUCTION, PC_OUT and HIT_OUT (instruction valid) to decode.
- Handles pipeline stall, taken-branch redirect and squash of in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
STALL  input  1  decode/hazard stall; hold IF/ID contents, start no new fetch
BRANCH_TAKEN  input  1  redirect request, single-cycle pulse
BRANCH_TARGET  input  32  redirect address, valid with BRANCH_TAKEN
IMEM_REQ  output  1  fetch request
IMEM_ADDR  output  32  fetch address, stable while IMEM_REQ=1
IMEM_READY  input  1  memory accepted request; IMEM_RDATA valid this cycle
IMEM_RDATA  input  32  fetched word
INSTRUCTION  output  32  IF/ID instruction
PC_OUT  output  32  address of INSTRUCTION
PC_PLUS4  output  32  PC_OUT + PC_STEP
HIT_OUT  output  1  INSTRUCTION valid
STALL_CYCLES  output  32  fetch stall counter (see Optional Feature)

Behaviour:
- Reset (rst_n low, async):
  - PC=RESET_PC, REQ_ADDR=RESET_PC, state=IDLE, SQUASH=0, BUF_VALID=0.
  - IMEM_REQ=0, INSTRUCTION=32'h0 (NOP), PC_OUT=0, PC_PLUS4=0, HIT_OUT=0, STALL_CYCLES=0.
- Internal registers: PC (next fetch address), REQ_ADDR (drives IMEM_ADDR), SQUASH flag, one-entry skid buffer BUF_INSTR/BUF_PC/BUF_VALID.
- Handshake:
  - IMEM_REQ, once high, stays high with IMEM_ADDR unchanged until a cycle with IMEM_READY=1.
  - Transfer completes on the rising edge where IMEM_REQ and IMEM_READY are both high.
  - With IMEM_READY tied high, throughput is 1 instruction/cycle; latency from IMEM_ADDR to INSTRUCTION is 1 clock.
- IDLE state: IMEM_REQ=0. If STALL=0, load REQ_ADDR<=PC and go to REQ.
- REQ state: IMEM_REQ=1, IMEM_ADDR=REQ_ADDR.
  - READY with SQUASH=1 or BRANCH_TAKEN=1: discard word and clear SQUASH. Go to REQ with REQ_ADDR = target/PC if STALL=0, else IDLE.
  - READY, no squash, STALL=0: INSTRUCTION<=IMEM_RDATA, PC_OUT<=REQ_ADDR, PC_PLUS4<=REQ_ADDR+PC_STEP, HIT_OUT<=1. PC<=REQ_ADDR+PC_STEP, and REQ_ADDR takes the same value. Stay in REQ.
  - READY, no squash, STALL=1: capture word in buffer (BUF_VALID=1), PC<=REQ_ADDR+PC_STEP, go to HOLD. IF/ID unchanged.
  - No READY, STALL=0: HIT_OUT<=0 (bubble).
  - No READY, STALL=1: IF/ID holds.
- HOLD state: IMEM_REQ=0, IF/ID holds.
  - When STALL=0: buffer -> IF/ID with HIT_OUT=1, BUF_VALID=0. REQ_ADDR<=PC; go to REQ.
- BRANCH_TAKEN (priority over STALL, any state): PC<=BRANCH_TARGET, HIT_OUT<=0 next cycle, BUF_VALID<=0.
  - In REQ without READY: SQUASH<=1. IMEM_ADDR keeps its old value until READY.
  - In IDLE or HOLD: go to REQ with REQ_ADDR=BRANCH_TARGET if STALL=0, else IDLE.
- Arithmetic: all PC math is 32-bit modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0 silently.
- BRANCH_TARGET low 2 bits are forced to 0.
- Reset mid-request: IMEM_REQ drops immediately (async). Any late IMEM_READY is ignored while in IDLE.

Optional Feature:
- Macro FETCH_STALL_COUNT_EN.
- Defined: STALL_CYCLES increments (saturating at 32'hFFFF_FFFF) every cycle in which HIT_OUT is low after the next edge and the state is REQ (waiting on memory) or SQUASH=1. Cleared only by reset.
- Undefined: STALL_CYCLES is tied to 32'h0 and no counter logic is built.

Test Plan:
- Reset release, IMEM_READY tied 1, IMEM_RDATA = address ^ 32'hA5A5_0000 -> first HIT_OUT=1 at 2nd edge with PC_OUT=0; then PC_OUT 4, 8, 12 on consecutive cycles.
- IMEM_READY low for 3 cycles at address 0x8 -> IMEM_ADDR held at 0x8, HIT_OUT=0 for 3 cycles; INSTRUCTION then matches word for 0x8; STALL_CYCLES=3 when enabled.
- STALL high 2 cycles while a word for 0x10 returns -> IF/ID keeps 0xC contents; 0x10 appears, HIT_OUT=1, on the cycle after STALL falls; no duplicate or lost instruction.
- BRANCH_TAKEN to 0x100 while request for 0x20 is waiting -> word for 0x20 discarded, next IMEM_ADDR=0x100, next valid PC_OUT=0x100.
- BRANCH_TAKEN and STALL both high in HOLD -> buffer dropped, IMEM_REQ=0; after STALL falls, fetch starts at target.
- rst_n asserted mid-REQ -> all outputs at reset values immediately; after release, fetch resumes at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory request/response bundle for fetch_stage
interface fetch_stage_if;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_READY;
    logic [31:0] IMEM_RDATA;

    modport master (
        output IMEM_REQ,
        output IMEM_ADDR,
        input  IMEM_READY,
        input  IMEM_RDATA
    );

    modport slave (
        input  IMEM_REQ,
        input  IMEM_ADDR,
        output IMEM_READY,
        output IMEM_RDATA
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register; optional FETCH_STALL_COUNT_EN stall counter
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 STALL,
    input  logic                 BRANCH_TAKEN,
    input  logic [31:0]          BRANCH_TARGET,
    fetch_stage_if.master        imem,
    output logic [31:0]          INSTRUCTION,
    output logic [31:0]          PC_OUT,
    output logic [31:0]          PC_PLUS4,
    output logic                 HIT_OUT,
    output logic [31:0]          STALL_CYCLES
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] pc;
    logic [31:0] req_addr;
    logic        squash;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc;
    logic        buf_valid;

    logic [31:0] target;
    logic [31:0] seq_addr;
    logic [31:0] redirect_addr;
    logic        accept;
    logic        drop;

    logic        take_mem;
    logic        take_buf;
    logic        capture;
    logic        bubble;
    logic        hit_next;
    logic        load_req_redirect;

    // Instruction words are word-aligned; the low address bits of a target are ignored.
    assign target        = BRANCH_TARGET & ~32'h3;
    assign seq_addr      = req_addr + PC_STEP;
    assign redirect_addr = BRANCH_TAKEN ? target : pc;
    assign accept        = (state == S_REQ) && imem.IMEM_READY;
    assign drop          = accept && (squash || BRANCH_TAKEN);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection; a stall parks the FSM in IDLE or HOLD so no new fetch starts.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (!STALL) state_next = S_REQ;
            end
            S_REQ: begin
                if (accept) begin
                    if (drop) state_next = STALL ? S_IDLE : S_REQ;
                    else      state_next = STALL ? S_HOLD : S_REQ;
                end
            end
            S_HOLD: begin
                if (BRANCH_TAKEN || !STALL) state_next = STALL ? S_IDLE : S_REQ;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Bus outputs and datapath strobes derived from state and inputs.
    always_comb begin
        imem.IMEM_REQ     = (state == S_REQ);
        imem.IMEM_ADDR    = req_addr;
        take_mem          = accept && !drop && !STALL;
        take_buf          = (state == S_HOLD) && !BRANCH_TAKEN && !STALL;
        capture           = accept && !drop && STALL;
        bubble            = BRANCH_TAKEN
                          || ((state == S_REQ) && !imem.IMEM_READY && !STALL)
                          || (drop && !STALL)
                          || ((state == S_IDLE) && !STALL);
        load_req_redirect = !STALL && ((state == S_IDLE) || (state == S_HOLD) || drop);
        hit_next          = HIT_OUT;
        if (take_mem || take_buf) hit_next = 1'b1;
        else if (bubble)          hit_next = 1'b0;
    end

    // PC, request address, squash flag and skid buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            req_addr  <= RESET_PC;
            squash    <= 1'b0;
            buf_instr <= 32'h0;
            buf_pc    <= 32'h0;
            buf_valid <= 1'b0;
        end else begin
            if (BRANCH_TAKEN)             pc <= target;
            else if (accept && !drop)     pc <= seq_addr;

            if (load_req_redirect)        req_addr <= redirect_addr;
            else if (take_mem)            req_addr <= seq_addr;

            // An in-flight request redirected before it completes must have its word discarded.
            if (accept)                   squash <= 1'b0;
            else if ((state == S_REQ) && BRANCH_TAKEN) squash <= 1'b1;

            if (capture) begin
                buf_instr <= imem.IMEM_RDATA;
                buf_pc    <= req_addr;
                buf_valid <= 1'b1;
            end else if (BRANCH_TAKEN || take_buf) begin
                buf_valid <= 1'b0;
            end
        end
    end

    // IF/ID pipeline register presented to decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            INSTRUCTION <= 32'h0;
            PC_OUT      <= 32'h0;
            PC_PLUS4    <= 32'h0;
            HIT_OUT     <= 1'b0;
        end else begin
            HIT_OUT <= hit_next;
            if (take_mem) begin
                INSTRUCTION <= imem.IMEM_RDATA;
                PC_OUT      <= req_addr;
                PC_PLUS4    <= seq_addr;
            end else if (take_buf && buf_valid) begin
                INSTRUCTION <= buf_instr;
                PC_OUT      <= buf_pc;
                PC_PLUS4    <= buf_pc + PC_STEP;
            end
        end
    end

`ifdef FETCH_STALL_COUNT_EN
    logic [31:0] stall_cnt;

    // Count cycles where decode gets a bubble because memory is slow or a fetch is being squashed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 32'h0;
        end else if (!hit_next && ((state == S_REQ) || squash) && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign STALL_CYCLES = stall_cnt;
`else
    assign STALL_CYCLES = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    localparam logic [31:0] SALT = 32'hA5A5_0000;
`ifdef FETCH_STALL_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        hit_out;
    logic [31:0] stall_cycles;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_stage_if bus ();

    assign bus.IMEM_RDATA = bus.IMEM_ADDR ^ SALT;

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .STALL         (stall),
        .BRANCH_TAKEN  (br_taken),
        .BRANCH_TARGET (br_target),
        .imem          (bus),
        .INSTRUCTION   (instruction),
        .PC_OUT        (pc_out),
        .PC_PLUS4      (pc_plus4),
        .HIT_OUT       (hit_out),
        .STALL_CYCLES  (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_if(input string tag, input logic [31:0] pc);
        check_eq({tag, "_hit"},   {31'h0, hit_out}, 32'h1);
        check_eq({tag, "_pc"},    pc_out, pc);
        check_eq({tag, "_instr"}, instruction, pc ^ SALT);
        check_eq({tag, "_pc4"},   pc_plus4, pc + 32'd4);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        br_taken = 1'b0;
        br_target = 32'h0;
        bus.IMEM_READY = 1'b1;
        step();
        step();
        check_eq("rst_req",   {31'h0, bus.IMEM_REQ}, 32'h0);
        check_eq("rst_instr", instruction, 32'h0);
        check_eq("rst_pc",    pc_out, 32'h0);
        check_eq("rst_pc4",   pc_plus4, 32'h0);
        check_eq("rst_hit",   {31'h0, hit_out}, 32'h0);
        check_eq("rst_cnt",   stall_cycles, 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        // Sequential fetch at one instruction per cycle.
        do_reset();
        step();
        check_eq("a_req",  {31'h0, bus.IMEM_REQ}, 32'h1);
        check_eq("a_addr", bus.IMEM_ADDR, 32'h0);
        check_eq("a_hit0", {31'h0, hit_out}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_if("a_seq", 32'(i * 4));
        end

        // Memory wait states at 0x8.
        do_reset();
        step();
        step();
        step();
        check_eq("b_addr8", bus.IMEM_ADDR, 32'h8);
        bus.IMEM_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("b_hold_addr", bus.IMEM_ADDR, 32'h8);
            check_eq("b_bubble",    {31'h0, hit_out}, 32'h0);
        end
        bus.IMEM_READY = 1'b1;
        step();
        check_if("b_word8", 32'h8);
        check_eq("b_cnt", stall_cycles, CNT_EN ? 32'd3 : 32'd0);

        // Decode stall while the word for 0x10 returns.
        step();
        check_if("c_pre", 32'hC);
        stall = 1'b1;
        step();
        check_if("c_stall1", 32'hC);
        check_eq("c_req0", {31'h0, bus.IMEM_REQ}, 32'h0);
        step();
        check_if("c_stall2", 32'hC);
        stall = 1'b0;
        step();
        check_if("c_buf", 32'h10);
        step();
        check_if("c_next", 32'h14);

        // Redirect while request for 0x20 waits on memory.
        step();
        step();
        check_eq("d_addr20", bus.IMEM_ADDR, 32'h20);
        bus.IMEM_READY = 1'b0;
        br_taken = 1'b1;
        br_target = 32'h103;
        step();
        br_taken = 1'b0;
        check_eq("d_hit0",  {31'h0, hit_out}, 32'h0);
        check_eq("d_keep",  bus.IMEM_ADDR, 32'h20);
        step();
        check_eq("d_keep2", bus.IMEM_ADDR, 32'h20);
        bus.IMEM_READY = 1'b1;
        step();
        check_eq("d_drop",  {31'h0, hit_out}, 32'h0);
        check_eq("d_tgt",   bus.IMEM_ADDR, 32'h100);
        step();
        check_if("d_first", 32'h100);
        check_eq("d_cnt", stall_cycles, CNT_EN ? 32'd6 : 32'd0);

        // Redirect and stall together while holding a buffered word.
        stall = 1'b1;
        step();
        check_eq("e_hold_req", {31'h0, bus.IMEM_REQ}, 32'h0);
        check_eq("e_hold_pc",  pc_out, 32'h100);
        br_taken = 1'b1;
        br_target = 32'h200;
        step();
        br_taken = 1'b0;
        check_eq("e_hit0", {31'h0, hit_out}, 32'h0);
        check_eq("e_req0", {31'h0, bus.IMEM_REQ}, 32'h0);
        step();
        check_eq("e_idle", {31'h0, bus.IMEM_REQ}, 32'h0);
        stall = 1'b0;
        step();
        check_eq("e_req1", {31'h0, bus.IMEM_REQ}, 32'h1);
        check_eq("e_addr", bus.IMEM_ADDR, 32'h200);
        check_eq("e_hit",  {31'h0, hit_out}, 32'h0);
        step();
        check_if("e_first", 32'h200);

        // Asynchronous reset in the middle of a pending request.
        bus.IMEM_READY = 1'b0;
        step();
        check_eq("f_pend", {31'h0, bus.IMEM_REQ}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("f_req",   {31'h0, bus.IMEM_REQ}, 32'h0);
        check_eq("f_hit",   {31'h0, hit_out}, 32'h0);
        check_eq("f_pc",    pc_out, 32'h0);
        check_eq("f_instr", instruction, 32'h0);
        check_eq("f_cnt",   stall_cycles, 32'h0);
        step();
        rst_n = 1'b1;
        bus.IMEM_READY = 1'b1;
        step();
        check_eq("f_addr", bus.IMEM_ADDR, 32'h0);
        step();
        check_if("f_resume", 32'h0);

        // Address wrap at the top of the address space.
        br_taken = 1'b1;
        br_target = 32'hFFFF_FFFF;
        step();
        br_taken = 1'b0;
        check_eq("g_tgt", bus.IMEM_ADDR, 32'hFFFF_FFFC);
        check_eq("g_hit", {31'h0, hit_out}, 32'h0);
        step();
        check_if("g_top", 32'hFFFF_FFFC);
        check_eq("g_wrap", bus.IMEM_ADDR, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
